// File: rtl/sw_demux_capture.sv
// Debounced 1-to-2 register demux: a KEY press latches SW[3:0] into X (SW[9]=1) or Y (SW[9]=0).
// Define SW_DEMUX_CAPTURE_AUTOCLEAR_EN to clear the unselected register on every load.
module sw_demux_capture #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [9:0] SW,
    input  logic       KEY,
    output logic [9:0] LEDR
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        LOAD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    logic [23:0] cnt;
    logic [3:0]  reg_x;
    logic [3:0]  reg_y;
    logic        busy;
    logic        key_meta;
    logic        k_sync;
    logic        unused_sw;

    assign unused_sw = ^SW[8:4];

    // KEY is asynchronous to the clock; both stages idle at the released level.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_meta <= 1'b1;
            k_sync   <= 1'b1;
        end else begin
            key_meta <= KEY;
            k_sync   <= key_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 24'd0;
            reg_x <= 4'h0;
            reg_y <= 4'h0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!k_sync) begin
                        state <= PRESS_WAIT;
                        cnt   <= 24'd0;
                        busy  <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (k_sync) begin
                        state <= IDLE;
                        cnt   <= 24'd0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOAD;
                        cnt   <= 24'd0;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                LOAD: begin
                    if (SW[9]) begin
                        reg_x <= SW[3:0];
`ifdef SW_DEMUX_CAPTURE_AUTOCLEAR_EN
                        reg_y <= 4'h0;
`endif
                    end else begin
                        reg_y <= SW[3:0];
`ifdef SW_DEMUX_CAPTURE_AUTOCLEAR_EN
                        reg_x <= 4'h0;
`endif
                    end
                    state <= RELEASE_WAIT;
                    cnt   <= 24'd0;
                end
                RELEASE_WAIT: begin
                    // Any low sample restarts the release count; held buttons never re-trigger.
                    if (!k_sync) begin
                        cnt <= 24'd0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= 24'd0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 24'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign LEDR = {SW[9], busy, reg_y, reg_x};

endmodule
